// File: rtl/display_pkg.sv
// Shared constants, state encoding and width helpers for the multiplexed display blocks.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SCAN  = 2'd2
  } scan_state_e;

  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_SLOT_TICKS = 4;
  localparam int DEF_ON_START   = 2;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Clock prescaler: one tick every TICK_DIV clocks while running, cleared on demand.
module scan_tick_gen
  import display_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int CW       = clog2_min1(TICK_DIV)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear)     cnt_d = '0;
    else if (run)  cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/anode_scanner.sv
// Self-timed anode scan controller: walks enabled digits, drives active-low anodes
// inside a guarded on-window, and emits slot/frame strobes for the segment mux.
module anode_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int SLOT_TICKS = DEF_SLOT_TICKS,
  parameter int ON_START   = DEF_ON_START,
  parameter int TICK_DIV   = 1,
  parameter int DW         = clog2_min1(NUM_DIGITS),
  parameter int PW         = clog2_min1(SLOT_TICKS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [PW-1:0]         on_len,
  output logic [NUM_DIGITS-1:0] an,
  output logic [DW-1:0]         digit_sel,
  output logic                  slot_start,
  output logic                  frame_start
);

  localparam int PHW        = clog2_min1(SLOT_TICKS);
  localparam int ON_EFF_MAX = SLOT_TICKS - ON_START;

  scan_state_e           fsm_q, fsm_d;
  logic [PHW-1:0]        phase_q, phase_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  slot_q, slot_d;
  logic                  frame_q, frame_d;
  logic                  tick;
  int                    on_eff;
  int                    ph;

  function automatic logic [DW-1:0] lowest_en(input logic [NUM_DIGITS-1:0] en);
    lowest_en = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--)
      if (en[i]) lowest_en = DW'(i);
  endfunction

  // Next enabled digit after cur, wrapping; cur itself if it is the only one, holds if none.
  function automatic logic [DW-1:0] next_en(input logic [DW-1:0] cur,
                                            input logic [NUM_DIGITS-1:0] en);
    int idx;
    next_en = cur;
    for (int i = NUM_DIGITS; i >= 1; i--) begin
      idx = (int'(cur) + i) % NUM_DIGITS;
      if (en[idx]) next_en = DW'(idx);
    end
  endfunction

  // The START clock already counts as the first prescaler clock of slot 0.
  scan_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (fsm_q == IDLE),
    .run     (fsm_q != IDLE),
    .tick    (tick)
  );

  assign on_eff = min_int(int'(on_len), ON_EFF_MAX);
  assign ph     = int'(phase_d);

  always_comb begin
    fsm_d   = fsm_q;
    phase_d = phase_q;
    digit_d = digit_q;
    slot_d  = 1'b0;
    frame_d = 1'b0;
    an_d    = '1;

    case (fsm_q)
      IDLE:    if (enable) fsm_d = START;
      START:   fsm_d = SCAN;
      SCAN:    if (!enable) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase

    if (fsm_d == START) begin
      phase_d = '0;
      digit_d = lowest_en(digit_en);
      slot_d  = 1'b1;
      frame_d = |digit_en;
    end else if (fsm_d == SCAN && tick) begin
      if (phase_q == PHW'(SLOT_TICKS - 1)) begin
        phase_d = '0;
        digit_d = next_en(digit_q, digit_en);
        slot_d  = 1'b1;
        frame_d = (|digit_en) && (digit_d == lowest_en(digit_en));
      end else begin
        phase_d = phase_q + PHW'(1);
      end
    end

    // Outputs are built from next-state so they line up with the state after the edge.
    for (int d = 0; d < NUM_DIGITS; d++)
      if (fsm_d == SCAN && int'(digit_d) == d && digit_en[d] &&
          ph >= ON_START && ph < ON_START + on_eff)
        an_d[d] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= IDLE;
      phase_q <= '0;
      digit_q <= '0;
      an_q    <= '1;
      slot_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      phase_q <= phase_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
    end
  end

  assign an          = an_q;
  assign digit_sel   = digit_q;
  assign slot_start  = slot_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_anode_scanner.sv
// Directed bench for anode_scanner: default instance plus a TICK_DIV=3 instance.
module tb_anode_scanner;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable;
  logic [3:0] digit_en;
  logic [2:0] on_len;

  logic [3:0] an,  an3;
  logic [1:0] sel, sel3;
  logic       slot, slot3, frame, frame3;

  int n_chk = 0;
  int n_err = 0;
  int seq_q[4];

  always #5 clk = ~clk;

  anode_scanner u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .digit_en(digit_en), .on_len(on_len),
    .an(an), .digit_sel(sel), .slot_start(slot), .frame_start(frame)
  );

  anode_scanner #(.TICK_DIV(3)) u_div3 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .digit_en(digit_en), .on_len(on_len),
    .an(an3), .digit_sel(sel3), .slot_start(slot3), .frame_start(frame3)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First step lands on a slot-start edge; seq_q lists the digit owning each slot.
  task automatic expect_slots(input string tag, input int nslots, input logic [3:0] en,
                              input int low, input int oneff);
    int ph, d;
    logic [3:0] exp_an;
    for (int k = 0; k < nslots * 4; k++) begin
      step();
      ph = k % 4;
      d  = seq_q[(k / 4) % 4];
      exp_an = 4'hF;
      if (en[d] && ph >= 2 && ph < 2 + oneff) exp_an[d] = 1'b0;
      chk({tag, "/an"},    int'(an),    int'(exp_an));
      chk({tag, "/sel"},   int'(sel),   d);
      chk({tag, "/slot"},  int'(slot),  int'(ph == 0));
      chk({tag, "/frame"}, int'(frame), int'(ph == 0 && d == low));
    end
  endtask

  initial begin
    int ph3, d3;
    logic [3:0] exp_an3;

    enable   = 1'b0;
    digit_en = 4'hF;
    on_len   = 3'd1;

    #2 reset_n = 1'b0;
    #1;
    chk("rst/an",    int'(an),    15);
    chk("rst/sel",   int'(sel),   0);
    chk("rst/slot",  int'(slot),  0);
    chk("rst/frame", int'(frame), 0);
    chk("rst/an3",   int'(an3),   15);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("idle/an",   int'(an),   15);
      chk("idle/slot", int'(slot), 0);
    end

    enable = 1'b1;
    seq_q = '{0, 1, 2, 3};
    expect_slots("all4", 8, 4'hF, 0, 1);

    digit_en = 4'b0101;
    seq_q = '{0, 2, 0, 2};
    expect_slots("en0101", 4, 4'b0101, 0, 1);

    digit_en = 4'b0000;
    seq_q = '{2, 2, 2, 2};
    expect_slots("en0000", 2, 4'b0000, -1, 1);

    digit_en = 4'hF;
    on_len = 3'd2;
    seq_q = '{3, 0, 1, 2};
    expect_slots("len2", 4, 4'hF, 0, 2);
    on_len = 3'd7;
    expect_slots("len7", 4, 4'hF, 0, 2);
    on_len = 3'd0;
    expect_slots("len0", 4, 4'hF, 0, 0);
    on_len = 3'd1;
    expect_slots("len1", 2, 4'hF, 0, 1);

    step();
    chk("drop/slot", int'(slot), 1);
    chk("drop/sel",  int'(sel),  1);
    step();
    step();
    chk("drop/an_pre", int'(an), 13);
    enable = 1'b0;
    step();
    chk("drop/an",    int'(an),    15);
    chk("drop/sel1",  int'(sel),   1);
    chk("drop/slot0", int'(slot),  0);
    chk("drop/frame", int'(frame), 0);
    step();
    chk("drop/an2",   int'(an),  15);
    chk("drop/sel2",  int'(sel), 1);

    enable = 1'b1;
    seq_q = '{0, 1, 2, 3};
    expect_slots("restart", 4, 4'hF, 0, 1);

    for (int i = 0; i < 7; i++) step();
    chk("arst/an_pre",  int'(an),  13);
    chk("arst/sel_pre", int'(sel), 1);
    #3 reset_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("arst/an",    int'(an),    15);
    chk("arst/sel",   int'(sel),   0);
    chk("arst/slot",  int'(slot),  0);
    chk("arst/frame", int'(frame), 0);
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("arst/idle_an",   int'(an),   15);
      chk("arst/idle_slot", int'(slot), 0);
      chk("arst/idle_sel",  int'(sel),  0);
    end

    enable = 1'b1;
    for (int k = 0; k < 24; k++) begin
      step();
      ph3 = k % 12;
      d3  = k / 12;
      exp_an3 = 4'hF;
      if (ph3 >= 6 && ph3 < 9) exp_an3[d3] = 1'b0;
      chk("div3/an",    int'(an3),    int'(exp_an3));
      chk("div3/sel",   int'(sel3),   d3);
      chk("div3/slot",  int'(slot3),  int'(ph3 == 0));
      chk("div3/frame", int'(frame3), int'(ph3 == 0 && d3 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
